// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding and packer sizing.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    BYTE  = 3'd2,
    WRITE = 3'd3,
    CHK   = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int IDX_W      = $clog2(WORD_BYTES);

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs four stream bytes MSB-first into a 32-bit word; flags when the word is complete.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic        consume,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        last_byte,
  output logic        word_full
);

  logic [31:0]      shift_reg;
  logic [IDX_W-1:0] idx_reg;

  assign word_next = {shift_reg[23:0], byte_in};
  assign last_byte = (idx_reg == IDX_W'(WORD_BYTES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg <= '0;
      idx_reg   <= '0;
      word_full <= 1'b0;
    end else if (clear) begin
      shift_reg <= '0;
      idx_reg   <= '0;
      word_full <= 1'b0;
    end else if (shift_en && !word_full) begin
      // The index wraps to 0 on the fourth byte, ready for the next word.
      shift_reg <= word_next;
      idx_reg   <= idx_reg + IDX_W'(1);
      if (last_byte) word_full <= 1'b1;
    end else if (consume) begin
      word_full <= 1'b0;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory write port; holds the CPU until the image is in.
// Optional trailing-checksum check is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W:0]   word_count,
  output logic              load_done,
  output logic              cpu_hold,
  output logic              load_err
);

  localparam int DEPTH = 1 << ADDR_W;

  state_t          state_reg;
  logic [ADDR_W:0] len_reg;
  logic [ADDR_W:0] n_words;
  logic [ADDR_W:0] count_inc;
  logic            xfer;
  logic            pk_clear;
  logic            pk_shift;
  logic            pk_consume;
  logic [31:0]     pk_word_next;
  logic            pk_last;
  logic            pk_full;

  assign xfer       = byte_valid && byte_ready;
  assign count_inc  = word_count + (ADDR_W + 1)'(1);
  assign pk_clear   = start && (state_reg == IDLE || state_reg == DONE);
  assign pk_shift   = xfer && (state_reg == BYTE);
  assign pk_consume = (state_reg == WRITE);

  // A zero or oversized length byte means a full-depth image.
  always_comb begin
    n_words = (ADDR_W + 1)'(DEPTH);
    if (byte_in != 8'd0 && int'(byte_in) <= DEPTH) n_words = (ADDR_W + 1)'(byte_in);
  end

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (pk_clear),
    .shift_en  (pk_shift),
    .consume   (pk_consume),
    .byte_in   (byte_in),
    .word_next (pk_word_next),
    .last_byte (pk_last),
    .word_full (pk_full)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_reg;
  logic       load_err_reg;
  assign load_err = load_err_reg;
`else
  assign load_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      len_reg      <= '0;
      byte_ready   <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      word_count   <= '0;
      load_done    <= 1'b0;
      cpu_hold     <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_reg     <= '0;
      load_err_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg  <= LEN;
            byte_ready <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_reg   <= '0;
`endif
          end
        end
        LEN: begin
          if (xfer) begin
            len_reg    <= n_words;
            word_count <= '0;
            wr_addr    <= '0;
            state_reg  <= BYTE;
          end
        end
        BYTE: begin
          if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_reg <= csum_reg ^ byte_in;
`endif
            if (pk_last) begin
              wr_data    <= pk_word_next;
              wr_en      <= 1'b1;
              byte_ready <= 1'b0;
              state_reg  <= WRITE;
            end
          end
        end
        WRITE: begin
          wr_en <= 1'b0;
          // word_full is always set here; gating keeps a stray WRITE from advancing.
          if (pk_full) begin
            word_count <= count_inc;
            if (count_inc == len_reg) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_reg  <= CHK;
              byte_ready <= 1'b1;
`else
              state_reg  <= DONE;
              load_done  <= 1'b1;
              cpu_hold   <= 1'b0;
`endif
            end else begin
              wr_addr    <= wr_addr + ADDR_W'(1);
              byte_ready <= 1'b1;
              state_reg  <= BYTE;
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (xfer) begin
            byte_ready   <= 1'b0;
            load_done    <= 1'b1;
            load_err_reg <= (byte_in != csum_reg);
            cpu_hold     <= (byte_in != csum_reg);
            state_reg    <= DONE;
          end
        end
`endif
        DONE: begin
          if (start) begin
            state_reg    <= LEN;
            byte_ready   <= 1'b1;
            load_done    <= 1'b0;
            cpu_hold     <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            load_err_reg <= 1'b0;
            csum_reg     <= '0;
`endif
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
